// File: rtl/l1d_fifo_pkg.sv
`default_nettype none
// ============================================================================
// l1d_fifo_pkg : shared pointer-width helper for L1D register FIFOs
// Rev 1.0
// ============================================================================
package l1d_fifo_pkg;

  // Pointer carries one extra wrap bit above the index bits.
  function automatic int fifo_ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage : l1d_fifo_pkg
`default_nettype wire

// File: rtl/reg_dual_ram.sv
`default_nettype none
// ============================================================================
// reg_dual_ram : flop-based storage, one write port, one comb read port
// Rev 1.0
// ============================================================================
module reg_dual_ram #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] wa_i,
  input  logic [WIDTH-1:0]         wd_i,
  input  logic                     re_i,
  input  logic [$clog2(DEPTH)-1:0] ra_i,
  output logic [WIDTH-1:0]         rd_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[wa_i] <= wd_i;
    end
  end

  // Read data forced to zero when the reader is not enabled.
  assign rd_o = re_i ? mem_q[ra_i] : '0;

endmodule : reg_dual_ram
`default_nettype wire

// File: rtl/l1d_reg_fifo.sv
`default_nettype none
// ============================================================================
// l1d_reg_fifo : valid/ready FIFO over reg_dual_ram with flush and occupancy
// Optional empty-bypass path enabled by defining FIFO_BYPASS_EN.  Rev 1.0
// ============================================================================
module l1d_reg_fifo
  import l1d_fifo_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  input  logic                       enq_vld_i,
  output logic                       enq_rdy_o,
  input  logic [WIDTH-1:0]           enq_data_i,
  output logic                       deq_vld_o,
  input  logic                       deq_rdy_i,
  output logic [WIDTH-1:0]           deq_data_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int FIFO_PTR_W = fifo_ptr_w(DEPTH);
  localparam int IDX_W      = FIFO_PTR_W - 1;

  logic [FIFO_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_PTR_W-1:0] rd_ptr_q, rd_ptr_d;

  logic             w_empty;
  logic             w_full;
  logic             w_enq_fire;
  logic             w_deq_fire;
  logic             w_byp_take;
  logic             w_wr_adv;
  logic             w_rd_adv;
  logic [WIDTH-1:0] w_ram_rdata;

  assign w_empty = (wr_ptr_q == rd_ptr_q);
  assign w_full  = (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]) &&
                   (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]);

  assign enq_rdy_o = ~w_full & ~rst;
  assign count_o   = wr_ptr_q - rd_ptr_q;

`ifdef FIFO_BYPASS_EN
  logic w_byp;

  // Empty FIFO presents the incoming entry directly to the consumer.
  assign w_byp      = w_empty & enq_vld_i & ~flush_i & ~rst;
  assign w_byp_take = w_byp & deq_rdy_i;
  assign deq_vld_o  = w_byp | (~w_empty & ~rst);
  assign deq_data_o = w_byp ? enq_data_i : w_ram_rdata;
`else
  assign w_byp_take = 1'b0;
  assign deq_vld_o  = ~w_empty & ~rst;
  assign deq_data_o = w_ram_rdata;
`endif

  assign w_enq_fire = enq_vld_i & enq_rdy_o;
  assign w_deq_fire = deq_vld_o & deq_rdy_i;

  // A bypass-consumed entry never touches storage or the pointers.
  assign w_wr_adv = w_enq_fire & ~w_byp_take & ~flush_i;
  assign w_rd_adv = w_deq_fire & ~w_byp_take & ~flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (w_wr_adv) wr_ptr_d = wr_ptr_q + FIFO_PTR_W'(1);
      if (w_rd_adv) rd_ptr_d = rd_ptr_q + FIFO_PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  reg_dual_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk  (clk),
    .rst  (rst),
    .we_i (w_wr_adv),
    .wa_i (wr_ptr_q[IDX_W-1:0]),
    .wd_i (enq_data_i),
    .re_i (~w_empty),
    .ra_i (rd_ptr_q[IDX_W-1:0]),
    .rd_o (w_ram_rdata)
  );

endmodule : l1d_reg_fifo
`default_nettype wire

// File: tb/tb_l1d_reg_fifo.sv
`default_nettype none
// ============================================================================
// tb_l1d_reg_fifo : scoreboard bench for l1d_reg_fifo (default or bypass build)
// Rev 1.0
// ============================================================================
module tb_l1d_reg_fifo;

  localparam int WIDTH = 64;
  localparam int DEPTH = 8;
`ifdef FIFO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic             clk;
  logic             rst;
  logic             flush_i;
  logic             enq_vld_i;
  logic             enq_rdy_o;
  logic [WIDTH-1:0] enq_data_i;
  logic             deq_vld_o;
  logic             deq_rdy_i;
  logic [WIDTH-1:0] deq_data_o;
  logic [3:0]       count_o;

  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] sb [$];

  l1d_reg_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (flush_i),
    .enq_vld_i  (enq_vld_i),
    .enq_rdy_o  (enq_rdy_o),
    .enq_data_i (enq_data_i),
    .deq_vld_o  (deq_vld_o),
    .deq_rdy_i  (deq_rdy_i),
    .deq_data_o (deq_data_o),
    .count_o    (count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive at negedge, check outputs 1ns later, update the model.
  task automatic step(input logic ev, input logic [63:0] ed, input logic dr,
                      input logic fl, input logic rs);
    int          cnt;
    logic        exp_rdy;
    logic        exp_vld;
    logic        byp;
    logic [63:0] exp_data;
    logic [63:0] popped;
    enq_vld_i  = ev;
    enq_data_i = ed;
    deq_rdy_i  = dr;
    flush_i    = fl;
    rst        = rs;
    #1;
    cnt      = sb.size();
    exp_rdy  = !rs && (cnt < DEPTH);
    byp      = BYP && (cnt == 0) && ev && !fl && !rs;
    exp_vld  = byp || (!rs && (cnt > 0));
    exp_data = byp ? ed : ((cnt > 0) ? sb[0] : 64'd0);
    chk("enq_rdy", 64'(enq_rdy_o), 64'(exp_rdy));
    chk("deq_vld", 64'(deq_vld_o), 64'(exp_vld));
    chk("count", 64'(count_o), 64'(cnt));
    if (!rs) chk("deq_data", deq_data_o, exp_data);
    if (rs || fl) begin
      sb.delete();
    end else begin
      if (byp && dr) begin
        chk("byp_data", deq_data_o, ed);
      end else begin
        if (exp_vld && dr) begin
          popped = sb.pop_front();
          chk("sb_pop", deq_data_o, popped);
        end
        if (exp_rdy && ev) sb.push_back(ed);
      end
    end
    @(negedge clk);
  endtask

  task automatic drain();
    for (int k = 0; k < 2 * DEPTH && sb.size() > 0; k++) step(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; flush_i = 1'b0; enq_vld_i = 1'b0; enq_data_i = '0; deq_rdy_i = 1'b0;
    repeat (3) @(negedge clk);

    // Fill 0x1..0x8 without consuming; then full with head 0x1
    for (int i = 1; i <= 8; i++) step(1'b1, 64'(i), 1'b0, 1'b0, 1'b0);
    step(1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
    chk("full_cnt", 64'(count_o), 64'd8);

    // Pop all eight in order
    for (int i = 0; i < 8; i++) step(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 64'd0, 1'b0, 1'b0, 1'b0);

    // Steady-state enq+deq at level 3, wraps pointers
    for (int i = 0; i < 3; i++) step(1'b1, 64'h300 + 64'(i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, 64'h310 + 64'(i), 1'b1, 1'b0, 1'b0);
    drain();

    // At full, simultaneous enq+deq: only deq fires
    for (int i = 0; i < 8; i++) step(1'b1, 64'h400 + 64'(i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 64'h4FF, 1'b1, 1'b0, 1'b0);
    step(1'b1, 64'h4FE, 1'b0, 1'b0, 1'b0);
    drain();

    // Flush at level 5 with an enqueue in the same cycle
    for (int i = 0; i < 5; i++) step(1'b1, 64'h500 + 64'(i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 64'h5AA, 1'b1, 1'b1, 1'b0);
    step(1'b0, 64'd0, 1'b0, 1'b0, 1'b0);

    // Empty enqueue with consumer ready: bypass or one-cycle latency
    step(1'b1, 64'hAB, 1'b1, 1'b0, 1'b0);
    step(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 64'd0, 1'b0, 1'b0, 1'b0);

    // Reset mid-operation at level 4
    for (int i = 0; i < 4; i++) step(1'b1, 64'h700 + 64'(i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 64'h7EE, 1'b1, 1'b0, 1'b1);
    step(1'b1, 64'h7EF, 1'b1, 1'b0, 1'b1);
    step(1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 64'h7AA, 1'b0, 1'b0, 1'b0);
    drain();
    step(1'b0, 64'd0, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish by 200000");
    $fatal(1);
  end

endmodule : tb_l1d_reg_fifo
`default_nettype wire
